// File: rtl/tone_sample_gen.sv
// -----------------------------------------------------------------------------
// tone_sample_gen
//
// Stereo square-wave sample source for the I2S-style serializer (speaker_ctl).
// Runs on the serial bit clock and keeps a 32-slot frame counter in lock-step
// with the serializer's bit counter. Each channel has a half-period divider
// driving a phase flip-flop. A shared volume index selects the amplitude.
// The audio outputs are reloaded only on the last slot of a frame, so the new
// word is visible exactly when the serializer starts the left MSB and a word is
// never torn mid-shift.
//
// Optional feature macro: TONE_RAMP_EN
//   defined   : the amplitude index moves one step per frame toward its target
//               (volume, or 0 while muted/disabled), giving click-free ramps.
//   undefined : the amplitude index jumps straight to its target at the frame
//               boundary.
//
// Parameters
//   DIV_W          width of the half-period dividers, in clock cycles
//   FRAME_LEN      serial clocks per stereo frame (frame counter is 5 bits)
//
// Ports
//   clk_25div4MHz  in   1      serial bit clock (6.25 MHz), shared with serializer
//   rst            in   1      asynchronous, active-high reset
//   en             in   1      1 = generate tone, 0 = silence from next frame
//   mute           in   1      1 = zero samples from next frame, phases keep running
//   note_div_left  in   DIV_W  left half-period in clocks, 0 = silent channel
//   note_div_right in   DIV_W  right half-period in clocks, 0 = silent channel
//   volume         in   3      amplitude index 0..7
//   audio_left     out  16     signed left sample, stable for a whole frame
//   audio_right    out  16     signed right sample, stable for a whole frame
//   frame_start    out  1      one-cycle pulse while the frame counter is 0
// -----------------------------------------------------------------------------
module tone_sample_gen #(
  parameter int DIV_W     = 16,
  parameter int FRAME_LEN = 32
) (
  input  logic             clk_25div4MHz,
  input  logic             rst,
  input  logic             en,
  input  logic             mute,
  input  logic [DIV_W-1:0] note_div_left,
  input  logic [DIV_W-1:0] note_div_right,
  input  logic [2:0]       volume,
  output logic [15:0]      audio_left,
  output logic [15:0]      audio_right,
  output logic             frame_start
);

  localparam logic [4:0]       FRAME_LAST = 5'(FRAME_LEN - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE    = {{(DIV_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Amplitude lookup: volume index to positive sample magnitude.
  function automatic logic [15:0] amp_lut(input logic [2:0] idx);
    logic [15:0] amp;
    case (idx)
      3'd0:    amp = 16'h0000;
      3'd1:    amp = 16'h0400;
      3'd2:    amp = 16'h0800;
      3'd3:    amp = 16'h1000;
      3'd4:    amp = 16'h2000;
      3'd5:    amp = 16'h3000;
      3'd6:    amp = 16'h5000;
      3'd7:    amp = 16'h7000;
      default: amp = 16'h0000;
    endcase
    return amp;
  endfunction

  // One clock of a phase generator; returns {phase, count}.
  // The >= compare means a divider lowered below the running count wraps on
  // the very next clock instead of counting all the way round the counter.
  function automatic logic [DIV_W:0] phase_step(
    input logic             run,
    input logic [DIV_W-1:0] div,
    input logic [DIV_W-1:0] cnt,
    input logic             phase
  );
    logic [DIV_W:0] nxt;
    if (!run) begin
      nxt = {phase, cnt};
    end else if (div == DIV_ZERO) begin
      nxt = {1'b0, DIV_ZERO};
    end else if (cnt >= (div - DIV_ONE)) begin
      nxt = {~phase, DIV_ZERO};
    end else begin
      nxt = {phase, cnt + DIV_ONE};
    end
    return nxt;
  endfunction

  // Square-wave sample: +amp on high phase, -amp on low phase, 0 when silent.
  function automatic logic [15:0] form_sample(
    input logic             phase,
    input logic [DIV_W-1:0] div,
    input logic [15:0]      amp
  );
    logic [15:0] smp;
    if (div == DIV_ZERO) begin
      smp = 16'h0000;
    end else if (phase) begin
      smp = amp;
    end else begin
      smp = 16'h0000 - amp;
    end
    return smp;
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [4:0]       frame_cnt_r;
  logic             upd_s;
  logic [DIV_W-1:0] cnt_left_r;
  logic [DIV_W-1:0] cnt_right_r;
  logic             phase_left_r;
  logic             phase_right_r;
  logic [DIV_W:0]   step_left_s;
  logic [DIV_W:0]   step_right_s;
  logic [2:0]       target_idx_s;
  logic [2:0]       amp_idx_s;
  logic [15:0]      amp_s;
  logic [15:0]      sample_left_s;
  logic [15:0]      sample_right_s;

  // Last slot of the frame: outputs reload here and appear at slot 0.
  always_comb begin
    upd_s = (frame_cnt_r == FRAME_LAST);
  end

  // Next phase-generator state for both channels.
  always_comb begin
    step_left_s  = phase_step(en, note_div_left,  cnt_left_r,  phase_left_r);
    step_right_s = phase_step(en, note_div_right, cnt_right_r, phase_right_r);
  end

  // Amplitude index target: silenced while muted or disabled.
  always_comb begin
    if (en && !mute) begin
      target_idx_s = volume;
    end else begin
      target_idx_s = 3'd0;
    end
  end

`ifdef TONE_RAMP_EN
  logic [2:0] amp_idx_r;

  // Ramp: move the stored index one step toward the target.
  always_comb begin
    amp_idx_s = amp_idx_r;
    if (amp_idx_r < target_idx_s) begin
      amp_idx_s = amp_idx_r + 3'd1;
    end else if (amp_idx_r > target_idx_s) begin
      amp_idx_s = amp_idx_r - 3'd1;
    end else begin
      amp_idx_s = amp_idx_r;
    end
  end

  // Amplitude index register, advanced once per frame.
  always_ff @(posedge clk_25div4MHz or posedge rst) begin
    if (rst) begin
      amp_idx_r <= 3'd0;
    end else if (upd_s) begin
      amp_idx_r <= amp_idx_s;
    end
  end
`else
  // Immediate mode: index jumps straight to the target.
  always_comb begin
    amp_idx_s = target_idx_s;
  end
`endif

  // Candidate samples, formed from the phase before any toggle at this edge.
  always_comb begin
    amp_s          = amp_lut(amp_idx_s);
    sample_left_s  = form_sample(phase_left_r,  note_div_left,  amp_s);
    sample_right_s = form_sample(phase_right_r, note_div_right, amp_s);
  end

  // Frame counter, frame_start pulse and phase generators.
  always_ff @(posedge clk_25div4MHz or posedge rst) begin
    if (rst) begin
      frame_cnt_r   <= 5'd0;
      frame_start   <= 1'b0;
      cnt_left_r    <= DIV_ZERO;
      cnt_right_r   <= DIV_ZERO;
      phase_left_r  <= 1'b0;
      phase_right_r <= 1'b0;
    end else begin
      if (upd_s) begin
        frame_cnt_r <= 5'd0;
      end else begin
        frame_cnt_r <= frame_cnt_r + 5'd1;
      end
      frame_start   <= upd_s;
      cnt_left_r    <= step_left_s[DIV_W-1:0];
      phase_left_r  <= step_left_s[DIV_W];
      cnt_right_r   <= step_right_s[DIV_W-1:0];
      phase_right_r <= step_right_s[DIV_W];
    end
  end

  // Output sample registers, reloaded only on the frame boundary.
  always_ff @(posedge clk_25div4MHz or posedge rst) begin
    if (rst) begin
      audio_left  <= 16'h0000;
      audio_right <= 16'h0000;
    end else if (upd_s) begin
      audio_left  <= sample_left_s;
      audio_right <= sample_right_s;
    end
  end

endmodule

// File: tb/tb_tone_sample_gen.sv
// -----------------------------------------------------------------------------
// tb_tone_sample_gen
//
// Directed self-checking bench for tone_sample_gen. After every reset release
// the clock edges are numbered from 1; the frame counter reads 31 just before
// every edge 32*m, so outputs loaded at that edge depend on the phase left by
// edge 32*m-1. With a constant divider d that phase is floor((32*m-1)/d) & 1.
// Expected values below are hand-computed from that rule.
// -----------------------------------------------------------------------------
module tb_tone_sample_gen;

  logic        clk_25div4MHz;
  logic        rst;
  logic        en;
  logic        mute;
  logic [15:0] note_div_left;
  logic [15:0] note_div_right;
  logic [2:0]  volume;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        frame_start;

  int tests_run;
  int tests_failed;
  int edge_no;

  tone_sample_gen #(.DIV_W(16), .FRAME_LEN(32)) dut (
    .clk_25div4MHz  (clk_25div4MHz),
    .rst            (rst),
    .en             (en),
    .mute           (mute),
    .note_div_left  (note_div_left),
    .note_div_right (note_div_right),
    .volume         (volume),
    .audio_left     (audio_left),
    .audio_right    (audio_right),
    .frame_start    (frame_start)
  );

  initial clk_25div4MHz = 1'b0;
  always #80 clk_25div4MHz = ~clk_25div4MHz;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk_25div4MHz);
      edge_no++;
    end
    @(negedge clk_25div4MHz);
  endtask

  task automatic run_to(input int k);
    adv(k - edge_no);
  endtask

  // Reset pulse (entered and left on a falling edge) with reset-state checks.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq({tag, " rst audio_left"},  audio_left,  16'h0000);
    check_eq({tag, " rst audio_right"}, audio_right, 16'h0000);
    check_eq({tag, " rst frame_start"}, {15'd0, frame_start}, 16'h0000);
    @(negedge clk_25div4MHz);
    @(negedge clk_25div4MHz);
    rst = 1'b0;
    edge_no = 0;
  endtask

  task automatic setup(input logic [15:0] dl, input logic [15:0] dr, input logic [2:0] vol);
    en             = 1'b1;
    mute           = 1'b0;
    note_div_left  = dl;
    note_div_right = dr;
    volume         = vol;
  endtask

`ifdef TONE_RAMP_EN
  logic [15:0] ramp_exp [1:14];
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    edge_no      = 0;
    rst          = 1'b1;
    setup(16'd4, 16'd0, 3'd7);

`ifdef TONE_RAMP_EN
    // Ramp up 0->7 in 7 frames, then mute ramps back to 0 in 7 frames.
    ramp_exp[1]  = 16'h0400; ramp_exp[2]  = 16'h0800; ramp_exp[3]  = 16'h1000;
    ramp_exp[4]  = 16'h2000; ramp_exp[5]  = 16'h3000; ramp_exp[6]  = 16'h5000;
    ramp_exp[7]  = 16'h7000; ramp_exp[8]  = 16'h5000; ramp_exp[9]  = 16'h3000;
    ramp_exp[10] = 16'h2000; ramp_exp[11] = 16'h1000; ramp_exp[12] = 16'h0800;
    ramp_exp[13] = 16'h0400; ramp_exp[14] = 16'h0000;
    do_reset("ramp");
    for (int m = 1; m <= 14; m++) begin
      run_to(32 * m);
      check_eq($sformatf("ramp frame %0d", m), audio_left, ramp_exp[m]);
      if (m == 7) mute = 1'b1;
    end
`else
    // Test 1: div_l=4, vol=7. First frame silent, then +0x7000.
    setup(16'd4, 16'd0, 3'd7);
    do_reset("t1");
    run_to(31);
    check_eq("t1 frame1 left", audio_left, 16'h0000);
    check_eq("t1 frame1 fs", {15'd0, frame_start}, 16'h0000);
    run_to(32);
    check_eq("t1 clk32 left", audio_left, 16'h7000);
    check_eq("t1 clk32 right", audio_right, 16'h0000);
    check_eq("t1 clk32 fs", {15'd0, frame_start}, 16'h0001);
    run_to(33);
    check_eq("t1 clk33 fs", {15'd0, frame_start}, 16'h0000);
    run_to(64);
    check_eq("t1 clk64 left", audio_left, 16'h7000);
    check_eq("t1 clk64 fs", {15'd0, frame_start}, 16'h0001);

    // Test 2: 1 kHz tone, toggles at edges 3125, 6250; seen at next boundary.
    setup(16'd3125, 16'd0, 3'd7);
    do_reset("t2");
    run_to(3104);
    check_eq("t2 clk3104 left", audio_left, 16'h9000);
    run_to(3135);
    check_eq("t2 hold after toggle", audio_left, 16'h9000);
    run_to(3136);
    check_eq("t2 clk3136 left", audio_left, 16'h7000);
    check_eq("t2 clk3136 fs", {15'd0, frame_start}, 16'h0001);
    run_to(6240);
    check_eq("t2 clk6240 left", audio_left, 16'h7000);
    run_to(6272);
    check_eq("t2 clk6272 left", audio_left, 16'h9000);

    // Test 3: divider 1000 lowered to 10 at count 500 -> wrap at edge 501.
    setup(16'd1000, 16'd0, 3'd7);
    do_reset("t3");
    run_to(480);
    check_eq("t3 clk480 left", audio_left, 16'h9000);
    run_to(500);
    note_div_left = 16'd10;
    run_to(512);
    check_eq("t3 clk512 left", audio_left, 16'h9000);
    run_to(544);
    check_eq("t3 clk544 left", audio_left, 16'h7000);
    run_to(576);
    check_eq("t3 clk576 left", audio_left, 16'h9000);
    run_to(608);
    check_eq("t3 clk608 left", audio_left, 16'h7000);

    // Test 4: mute pulse over slot 31 silences one frame; elsewhere no effect.
    setup(16'd4, 16'd0, 3'd7);
    do_reset("t4");
    run_to(62);
    mute = 1'b1;
    run_to(64);
    check_eq("t4 muted frame", audio_left, 16'h0000);
    run_to(65);
    mute = 1'b0;
    run_to(95);
    check_eq("t4 muted frame end", audio_left, 16'h0000);
    run_to(96);
    check_eq("t4 tone resumes", audio_left, 16'h7000);
    run_to(100);
    mute = 1'b1;
    run_to(103);
    mute = 1'b0;
    run_to(127);
    check_eq("t4 short mute hold", audio_left, 16'h7000);
    run_to(128);
    check_eq("t4 short mute next", audio_left, 16'h7000);

    // Test 5: asynchronous reset at frame_cnt 17, then clean restart.
    setup(16'd4, 16'd0, 3'd7);
    do_reset("t5");
    run_to(49);
    check_eq("t5 before rst", audio_left, 16'h7000);
    rst = 1'b1;
    #1;
    check_eq("t5 async rst left", audio_left, 16'h0000);
    check_eq("t5 async rst fs", {15'd0, frame_start}, 16'h0000);
    @(negedge clk_25div4MHz);
    rst = 1'b0;
    edge_no = 0;
    run_to(31);
    check_eq("t5 restart frame1", audio_left, 16'h0000);
    check_eq("t5 restart fs31", {15'd0, frame_start}, 16'h0000);
    run_to(32);
    check_eq("t5 restart clk32", audio_left, 16'h7000);
    check_eq("t5 restart fs32", {15'd0, frame_start}, 16'h0001);

    // Test 6: right channel div 6, volume changes at upd, en freezes phase.
    setup(16'd0, 16'd6, 3'd3);
    do_reset("t6");
    run_to(32);
    check_eq("t6 clk32 right", audio_right, 16'h1000);
    check_eq("t6 clk32 left", audio_left, 16'h0000);
    run_to(64);
    check_eq("t6 clk64 right", audio_right, 16'hF000);
    run_to(96);
    check_eq("t6 clk96 right", audio_right, 16'h1000);
    run_to(127);
    volume = 3'd5;
    run_to(128);
    check_eq("t6 vol change at upd", audio_right, 16'h3000);
    run_to(159);
    volume = 3'd0;
    run_to(160);
    check_eq("t6 vol zero", audio_right, 16'h0000);
    run_to(191);
    volume = 3'd7;
    en     = 1'b0;
    run_to(192);
    check_eq("t6 en low", audio_right, 16'h0000);
    run_to(224);
    en = 1'b1;
    // Edges 192..224 frozen: edge 255 acts like edge 222, phase 1.
    run_to(256);
    check_eq("t6 phase kept", audio_right, 16'h7000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
